// File: rtl/lib_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lib_pkg
// Brief   : Shared types and helpers for the lib_* arbiter/buffer blocks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package lib_pkg;

    typedef enum logic [0:0] {
        LIB_ARB_IDLE   = 1'b0,
        LIB_ARB_LOCKED = 1'b1
    } lib_arb_lock_e;

    // Index width that never collapses to zero for single-entry ranges
    function automatic int lib_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lib_skid_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lib_skid_buf
// Brief   : Two-entry (main + skid) registered output stage for valid/ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module lib_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_val,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_skid_empty,
    output logic             o_val,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_rdy
);

    logic             r_main_val;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_val;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_drain;

    assign w_drain      = r_main_val & i_rdy;
    assign o_val        = r_main_val;
    assign o_data       = r_main_data;
    assign o_skid_empty = ~r_skid_val;

    // i_val is a completed upstream handshake; upstream only accepts while
    // the skid entry is empty, so a push never collides with a full skid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_val  <= 1'b0;
            r_main_data <= '0;
            r_skid_val  <= 1'b0;
            r_skid_data <= '0;
        end else if (w_drain) begin
            if (r_skid_val) begin
                r_main_data <= r_skid_data;
                r_skid_val  <= 1'b0;
            end else if (i_val) begin
                r_main_data <= i_data;
            end else begin
                r_main_val  <= 1'b0;
            end
        end else if (i_val) begin
            if (!r_main_val) begin
                r_main_val  <= 1'b1;
                r_main_data <= i_data;
            end else begin
                r_skid_val  <= 1'b1;
                r_skid_data <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lib_arb_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lib_arb_mux
// Brief   : N-to-1 round-robin valid/ready mux with source tag and skid output.
//           Define LIB_ARB_MUX_PKT_LOCK_EN to hold the grant for whole packets.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module lib_arb_mux
    import lib_pkg::*;
#(
    parameter  int NUM_IN   = 4,
    parameter  int NUM_BITS = 32,
    localparam int SRC_W    = lib_clog2_min1(NUM_IN)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_IN-1:0]                in_val,
    input  logic [NUM_IN-1:0][NUM_BITS-1:0]  in_d,
    input  logic [NUM_IN-1:0]                in_last,
    output logic [NUM_IN-1:0]                in_rdy,
    output logic                             out_val,
    output logic [NUM_BITS-1:0]              out_d,
    output logic                             out_last,
    output logic [SRC_W-1:0]                 out_src,
    input  logic                             out_rdy
);

    localparam int PAY_W = 1 + SRC_W + NUM_BITS;
    localparam int SUM_W = SRC_W + 1;

    logic [SRC_W-1:0]  r_ptr;
    logic [NUM_IN-1:0] w_req;
    logic              w_any;
    logic [SRC_W-1:0]  w_idx;
    logic [SUM_W-1:0]  w_sum;
    logic              w_skid_empty;
    logic              w_acc;
    logic              w_push;
    logic              w_last;
    logic              w_adv;
    logic [PAY_W-1:0]  w_out_data;

    // First requester at or after the pointer, wrapping modulo NUM_IN
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sum = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_sum = {1'b0, r_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_IN)) begin
                w_sum = w_sum - SUM_W'(NUM_IN);
            end
            if (!w_any && w_req[w_sum[SRC_W-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[SRC_W-1:0];
            end
        end
    end

    assign w_acc  = rstn & w_skid_empty;
    assign w_push = w_acc & w_any;
    assign in_rdy = w_push ? (NUM_IN'(1) << w_idx) : '0;
    assign w_last = in_last[w_idx];

`ifdef LIB_ARB_MUX_PKT_LOCK_EN
    lib_arb_lock_e    r_state;
    logic [SRC_W-1:0] r_owner;

    // While locked, non-owners are masked even if the owner is idle
    assign w_req = (r_state == LIB_ARB_LOCKED) ? (in_val & (NUM_IN'(1) << r_owner)) : in_val;
    assign w_adv = w_push & w_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= LIB_ARB_IDLE;
            r_owner <= '0;
        end else if (w_push) begin
            case (r_state)
                LIB_ARB_IDLE: begin
                    if (!w_last) begin
                        r_state <= LIB_ARB_LOCKED;
                        r_owner <= w_idx;
                    end
                end
                LIB_ARB_LOCKED: begin
                    if (w_last) begin
                        r_state <= LIB_ARB_IDLE;
                    end
                end
                default: r_state <= LIB_ARB_IDLE;
            endcase
        end
    end
`else
    assign w_req = in_val;
    assign w_adv = w_push;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_adv) begin
            r_ptr <= (w_idx == SRC_W'(NUM_IN - 1)) ? '0 : w_idx + SRC_W'(1);
        end
    end

    lib_skid_buf #(
        .WIDTH (PAY_W)
    ) u_out (
        .clk          (clk),
        .rstn         (rstn),
        .i_val        (w_push),
        .i_data       ({w_last, w_idx, in_d[w_idx]}),
        .o_skid_empty (w_skid_empty),
        .o_val        (out_val),
        .o_data       (w_out_data),
        .i_rdy        (out_rdy)
    );

    assign {out_last, out_src, out_d} = w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_lib_arb_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_lib_arb_mux
// Brief   : Directed table-driven bench for lib_arb_mux (NUM_IN=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lib_arb_mux;

    localparam int NI = 4;
    localparam int NB = 32;
    localparam logic [31:0] DBASE = 32'hC0DE_0000;

    logic                clk;
    logic                rstn;
    logic [NI-1:0]       in_val;
    logic [NI-1:0][NB-1:0] in_d;
    logic [NI-1:0]       in_last;
    logic [NI-1:0]       in_rdy;
    logic                out_val;
    logic [NB-1:0]       out_d;
    logic                out_last;
    logic [1:0]          out_src;
    logic                out_rdy;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_oval;
        logic [1:0] e_src;
        logic       e_last;
    } vec_t;

    vec_t tbl[$];

    lib_arb_mux #(
        .NUM_IN   (NI),
        .NUM_BITS (NB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_val   (in_val),
        .in_d     (in_d),
        .in_last  (in_last),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_d    (out_d),
        .out_last (out_last),
        .out_src  (out_src),
        .out_rdy  (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] val, input logic [3:0] last,
                       input logic ordy, input logic [3:0] e_rdy, input logic e_oval,
                       input logic [1:0] e_src, input logic e_last);
        vec_t v;
        v.rst = rst; v.val = val; v.last = last; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_oval = e_oval; v.e_src = e_src; v.e_last = e_last;
        tbl.push_back(v);
    endtask

    // Holds reset across one rising edge; returns 1 time unit after that edge
    task automatic do_reset();
        in_val  = '0;
        in_last = '0;
        out_rdy = 1'b0;
        rstn    = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rstn   = 1'b0;
        in_val = '0;
        in_last = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < NI; i++) in_d[i] = DBASE | i;

        // All four requesting, single-beat packets, no backpressure
        add(1, 4'hF, 4'hF, 1, 4'b0001, 0, 0, 0);
        add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 1);
        add(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0001, 1, 3, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 1);
        add(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0001, 1, 3, 1);
        // Channels 0 and 2 with toggling downstream ready
        add(1, 4'h5, 4'hF, 1, 4'b0001, 0, 0, 0);
        add(0, 4'h5, 4'hF, 0, 4'b0100, 1, 0, 1);
        add(0, 4'h5, 4'hF, 1, 4'b0000, 1, 0, 1);
        add(0, 4'h5, 4'hF, 0, 4'b0001, 1, 2, 1);
        add(0, 4'h5, 4'hF, 1, 4'b0000, 1, 2, 1);
        add(0, 4'h5, 4'hF, 0, 4'b0100, 1, 0, 1);
        add(0, 4'h5, 4'hF, 1, 4'b0000, 1, 0, 1);
        add(0, 4'h5, 4'hF, 0, 4'b0001, 1, 2, 1);
        // Sustained backpressure: exactly two beats buffered, then drain
        add(1, 4'hF, 4'hF, 0, 4'b0001, 0, 0, 0);
        add(0, 4'hF, 4'hF, 0, 4'b0010, 1, 0, 1);
        add(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0, 1);
        add(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0, 1);
        add(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0000, 1, 0, 1);
        add(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 1);
        add(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 1);
`ifdef LIB_ARB_MUX_PKT_LOCK_EN
        // 3-beat packet on ch1 with a 2-cycle gap; others must stall
        add(1, 4'h2, 4'h0, 1, 4'b0010, 0, 0, 0);
        add(0, 4'h7, 4'h5, 1, 4'b0010, 1, 1, 0);
        add(0, 4'h5, 4'h5, 1, 4'b0000, 1, 1, 0);
        add(0, 4'h5, 4'h5, 1, 4'b0000, 0, 0, 0);
        add(0, 4'h7, 4'h7, 1, 4'b0010, 0, 0, 0);
        add(0, 4'h5, 4'h5, 1, 4'b0100, 1, 1, 1);
        add(0, 4'h5, 4'h5, 1, 4'b0001, 1, 2, 1);
        add(0, 4'h5, 4'h5, 1, 4'b0100, 1, 0, 1);
`else
        // 3-beat packet on ch1 interleaved per beat with ch2 and ch0
        add(1, 4'h2, 4'h0, 1, 4'b0010, 0, 0, 0);
        add(0, 4'h7, 4'h5, 1, 4'b0100, 1, 1, 0);
        add(0, 4'h7, 4'h5, 1, 4'b0001, 1, 2, 1);
        add(0, 4'h7, 4'h5, 1, 4'b0010, 1, 0, 1);
        add(0, 4'h7, 4'h7, 1, 4'b0100, 1, 1, 0);
        add(0, 4'h7, 4'h7, 1, 4'b0001, 1, 2, 1);
        add(0, 4'h7, 4'h7, 1, 4'b0010, 1, 0, 1);
        add(0, 4'h5, 4'h5, 1, 4'b0100, 1, 1, 1);
`endif

        @(posedge clk);
        #1;
        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            in_val  = tbl[r].val;
            in_last = tbl[r].last;
            out_rdy = tbl[r].ordy;
            #1;
            chk($sformatf("row%0d in_rdy", r), 32'(in_rdy), 32'(tbl[r].e_rdy));
            chk($sformatf("row%0d out_val", r), 32'(out_val), 32'(tbl[r].e_oval));
            if (tbl[r].e_oval) begin
                chk($sformatf("row%0d out_src", r), 32'(out_src), 32'(tbl[r].e_src));
                chk($sformatf("row%0d out_d", r), out_d, DBASE | 32'(tbl[r].e_src));
                chk($sformatf("row%0d out_last", r), 32'(out_last), 32'(tbl[r].e_last));
            end
            @(posedge clk);
            #1;
        end

        // Async reset with two ch1 mid-packet beats buffered
        do_reset();
        in_val  = 4'b0010;
        in_last = 4'b0000;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("prerst out_val", 32'(out_val), 32'd1);
        chk("prerst in_rdy", 32'(in_rdy), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async out_val", 32'(out_val), 32'd0);
        chk("async in_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        in_val  = 4'b0101;
        in_last = 4'b0101;
        out_rdy = 1'b1;
        #1;
        chk("postrst in_rdy", 32'(in_rdy), 32'b0001);
        chk("postrst out_val", 32'(out_val), 32'd0);
        @(posedge clk);
        #1;
        chk("postrst beat val", 32'(out_val), 32'd1);
        chk("postrst beat src", 32'(out_src), 32'd0);
        chk("postrst beat d", out_d, DBASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
